// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared types and constants for the SPI config controller
package spi_cfg_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_INC_BIT = 6;
  localparam logic [7:0] STATUS_DEFAULT = 8'hA5;
endpackage

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: NREG x 8 config storage, sync write, comb read mux under SPI_CFG_CTRL_READBACK_EN
module cfg_reg_bank #(
  parameter int NREG = 16,
  parameter int ADDR_W = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
`ifdef SPI_CFG_CTRL_READBACK_EN
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata,
`endif
  output logic [8*NREG-1:0] regs
);
  always_ff @(posedge clk) begin
    if (rst) regs <= {NREG{RESET_VAL}};
    else if (we)
      for (int i = 0; i < NREG; i++)
        if (waddr == ADDR_W'(i)) regs[8*i +: 8] <= wdata;
  end
`ifdef SPI_CFG_CTRL_READBACK_EN
  // addresses beyond NREG match no entry and read as zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++)
      if (raddr == ADDR_W'(i)) rdata = regs[8*i +: 8];
  end
`endif
endmodule

// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: SPI command/register controller with frame commit; readback under SPI_CFG_CTRL_READBACK_EN
module spi_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int NREG = 16,
  parameter int ADDR_W = 4,
  parameter logic [7:0] STATUS_BYTE = STATUS_DEFAULT,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rec_data,
  input  logic              rec_done,
  input  logic              cs_n,
  output logic [7:0]        response_data,
  output logic [8*NREG-1:0] cfg_regs,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              cfg_update,
  output logic              addr_err,
  output logic              busy
);
  localparam logic [ADDR_W:0] NREG_W = (ADDR_W+1)'(NREG);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
  state_t state, nstate;
  logic cs_n_d, inc, wrote, byte_ev, cmd_ev, dat_ev, wr_ev, we, rise;
  logic [ADDR_W-1:0] ptr, nptr;
`ifdef SPI_CFG_CTRL_READBACK_EN
  logic [ADDR_W-1:0] ra;
  logic [7:0] rd_data;
  logic rd_load;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : nstate;
  always_comb begin
    nstate = state;
    if (cs_n) nstate = IDLE;
    else if (state == IDLE) nstate = CMD;
    else if (state == CMD && rec_done) nstate = rec_data[CMD_RW_BIT] ? RD : WR;
  end
  // without readback RD acts as a discard state: bytes only advance ptr
  always_comb begin
    byte_ev = rec_done && state != IDLE;
    cmd_ev = byte_ev && state == CMD;
    dat_ev = byte_ev && (state == WR || state == RD);
    wr_ev = byte_ev && state == WR;
    we = wr_ev && ({1'b0, ptr} < NREG_W);
    nptr = !inc ? ptr : (ptr >= LAST) ? '0 : ptr + 1'b1;
    rise = !cs_n_d && cs_n;
  end
  assign busy = state != IDLE;
  cfg_reg_bank #(.NREG(NREG), .ADDR_W(ADDR_W), .RESET_VAL(RESET_VAL)) u_bank (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(ptr),
    .wdata(rec_data),
`ifdef SPI_CFG_CTRL_READBACK_EN
    .raddr(ra),
    .rdata(rd_data),
`endif
    .regs(cfg_regs)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_d <= 1'b1;
      ptr <= '0;
      inc <= 1'b0;
      wrote <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      cfg_update <= 1'b0;
    end else begin
      cs_n_d <= cs_n;
      ptr <= cmd_ev ? rec_data[ADDR_W-1:0] : dat_ev ? nptr : ptr;
      inc <= cmd_ev ? rec_data[CMD_INC_BIT] : inc;
      wr_strobe <= we;
      wr_addr <= we ? ptr : wr_addr;
      wrote <= !rise && (wrote || wr_ev);
      cfg_update <= rise && (wrote || wr_ev);
    end
  end
`ifdef SPI_CFG_CTRL_READBACK_EN
  // preload the byte for the next shift: command address first, then the advanced ptr
  always_comb begin
    ra = state == CMD ? rec_data[ADDR_W-1:0] : nptr;
    rd_load = byte_ev && nstate == RD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      response_data <= STATUS_BYTE;
      addr_err <= 1'b0;
    end else begin
      response_data <= rd_load ? rd_data : nstate == RD ? response_data : STATUS_BYTE;
      addr_err <= (wr_ev && !we) || (rd_load && {1'b0, ra} >= NREG_W);
    end
  end
`else
  assign response_data = STATUS_BYTE;
  always_ff @(posedge clk) addr_err <= rst ? 1'b0 : wr_ev && !we;
`endif
endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// tb_spi_cfg_ctrl: randomized frame-level check of spi_cfg_ctrl at NREG=16 and NREG=12
module tb_spi_cfg_ctrl;
  logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, rec_done = 1'b0;
  logic [7:0] rec_data = '0;
  logic [1:0] ws, ae, cu, bz;
  logic [7:0] rs [2];
  logic [3:0] wa [2];
  logic [127:0] regs16;
  logic [95:0] regs12;
  logic [7:0] mm [2][16];
  int nr [2] = '{16, 12};
  logic [7:0] fq [$];
  int tests = 0, fails = 0;
`ifdef SPI_CFG_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_cfg_ctrl u_dut16 (
    .clk(clk), .rst(rst), .rec_data(rec_data), .rec_done(rec_done), .cs_n(cs_n),
    .response_data(rs[0]), .cfg_regs(regs16), .wr_strobe(ws[0]), .wr_addr(wa[0]),
    .cfg_update(cu[0]), .addr_err(ae[0]), .busy(bz[0])
  );
  spi_cfg_ctrl #(.NREG(12)) u_dut12 (
    .clk(clk), .rst(rst), .rec_data(rec_data), .rec_done(rec_done), .cs_n(cs_n),
    .response_data(rs[1]), .cfg_regs(regs12), .wr_strobe(ws[1]), .wr_addr(wa[1]),
    .cfg_update(cu[1]), .addr_err(ae[1]), .busy(bz[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // address used for the k-th access after the command: step by one, wrapping at n
  function automatic int addr_at(int s, bit inc, int k, int n);
    int p = s;
    for (int i = 0; i < k; i++) if (inc) p = (p + 1 >= n) ? 0 : p + 1;
    return p;
  endfunction

  function automatic logic [7:0] reg_of(int j, int i);
    return j == 0 ? regs16[8*i +: 8] : regs12[8*i +: 8];
  endfunction

  function automatic int reg_bad(int j);
    int b = 0;
    for (int i = 0; i < nr[j]; i++) if (reg_of(j, i) !== mm[j][i]) b++;
    return b;
  endfunction

  task automatic do_frame;
    logic [7:0] c, rsp;
    int s, a, n, bad;
    bit inc, rd, wrote, st, er;
    c = fq[0];
    s = int'(c[3:0]);
    inc = c[6];
    rd = c[7];
    wrote = 1'b0;
    cs_n = 1'b0;
    tick;
    tests++;
    if (bz !== 2'b11 || cu !== 2'b00 || rs[0] !== 8'hA5 || rs[1] !== 8'hA5) begin
      fails++;
      $display("FAIL frame_open cmd=%h: busy=%b cfg_update=%b resp=%h/%h, expected 11 00 a5/a5", c, bz, cu, rs[0], rs[1]);
    end
    for (int k = 0; k < fq.size(); k++) begin
      rec_data = fq[k];
      rec_done = 1'b1;
      tick;
      rec_done = 1'b0;
      for (int j = 0; j < 2; j++) begin
        n = nr[j];
        st = 1'b0;
        er = 1'b0;
        rsp = 8'hA5;
        if (k == 0 || rd) begin
          a = addr_at(s, inc, k, n);
          if (rd && RB) begin
            er = a >= n;
            rsp = er ? 8'h00 : mm[j][a];
          end
        end else begin
          a = addr_at(s, inc, k - 1, n);
          st = a < n;
          er = !st;
          if (st) mm[j][a] = fq[k];
          wrote = 1'b1;
        end
        tests++;
        if ({ws[j], ae[j], rs[j]} !== {st, er, rsp} || (st && wa[j] !== 4'(a))) begin
          fails++;
          $display("FAIL byte cmd=%h k=%0d inst=%0d: strobe/err/resp/addr=%b/%b/%h/%0d, expected %b/%b/%h/%0d",
                   c, k, j, ws[j], ae[j], rs[j], wa[j], st, er, rsp, a);
        end
        bad = reg_bad(j);
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL regs cmd=%h k=%0d inst=%0d: %0d registers differ, expected 0", c, k, j, bad);
        end
      end
      tick;
      tick;
      tests++;
      if (ws !== 2'b00 || ae !== 2'b00) begin
        fails++;
        $display("FAIL strobe_len cmd=%h k=%0d: wr_strobe=%b addr_err=%b, expected 00 00", c, k, ws, ae);
      end
    end
    cs_n = 1'b1;
    tick;
    tests++;
    if (cu !== {wrote, wrote} || bz !== 2'b00) begin
      fails++;
      $display("FAIL frame_close cmd=%h: cfg_update=%b busy=%b, expected %b%b 00", c, cu, bz, wrote, wrote);
    end
  endtask

  task automatic test_reset;
    for (int j = 0; j < 2; j++) for (int i = 0; i < 16; i++) mm[j][i] = 8'h00;
    rst = 1'b1;
    cs_n = 1'b1;
    tick;
    tick;
    tests++;
    if (rs[0] !== 8'hA5 || rs[1] !== 8'hA5 || ws !== 0 || ae !== 0 || cu !== 0 || bz !== 0 ||
        wa[0] !== 0 || wa[1] !== 0 || regs16 !== '0 || regs12 !== '0) begin
      fails++;
      $display("FAIL reset: resp=%h/%h ws=%b ae=%b cu=%b busy=%b wa=%0d/%0d regs16=%h regs12=%h, expected a5 and zeros",
               rs[0], rs[1], ws, ae, cu, bz, wa[0], wa[1], regs16, regs12);
    end
    rst = 1'b0;
    tick;
    tests++;
    if (bz !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b, expected 00", bz);
    end
  endtask

  task automatic test_write;
    fq = '{8'h43, 8'h11, 8'h22, 8'h33};
    do_frame;
  endtask

  task automatic test_wrap;
    fq = '{8'h4F, 8'hAA, 8'hBB};
    do_frame;
  endtask

  task automatic test_out_of_range;
    fq = '{8'h0E, 8'h55};
    do_frame;
  endtask

  task automatic test_readback;
    fq = '{8'h42, 8'h5C, 8'hC5};
    do_frame;
    fq = '{8'hC2, 8'h00, 8'h00};
    do_frame;
  endtask

  task automatic test_back_to_back;
    repeat (24) begin
      fq.delete();
      fq.push_back(8'($urandom));
      repeat ($urandom_range(0, 5)) fq.push_back(8'($urandom));
      do_frame;
    end
  endtask

  task automatic test_simultaneous;
    cs_n = 1'b0;
    tick;
    rec_data = 8'h47;
    rec_done = 1'b1;
    tick;
    rec_done = 1'b0;
    tick;
    rec_data = 8'h99;
    rec_done = 1'b1;
    cs_n = 1'b1;
    tick;
    rec_done = 1'b0;
    mm[0][7] = 8'h99;
    mm[1][7] = 8'h99;
    tests++;
    if (ws !== 2'b11 || wa[0] !== 4'd7 || wa[1] !== 4'd7 || cu !== 2'b11 || bz !== 2'b00 ||
        reg_bad(0) != 0 || reg_bad(1) != 0) begin
      fails++;
      $display("FAIL simultaneous: ws=%b wa=%0d/%0d cu=%b busy=%b reg7=%h/%h, expected 11 7/7 11 00 99/99",
               ws, wa[0], wa[1], cu, bz, regs16[63:56], regs12[63:56]);
    end
    tick;
    tests++;
    if (cu !== 2'b00) begin
      fails++;
      $display("FAIL update_len: cfg_update=%b, expected 00", cu);
    end
  endtask

  task automatic test_abort;
    cs_n = 1'b0;
    repeat (4) tick;
    tests++;
    if (bz !== 2'b11) begin
      fails++;
      $display("FAIL abort_busy: busy=%b, expected 11", bz);
    end
    cs_n = 1'b1;
    tick;
    tests++;
    if (bz !== 2'b00 || cu !== 2'b00 || reg_bad(0) != 0 || reg_bad(1) != 0) begin
      fails++;
      $display("FAIL abort: busy=%b cfg_update=%b bad_regs=%0d/%0d, expected 00 00 0/0", bz, cu, reg_bad(0), reg_bad(1));
    end
  endtask

  task automatic test_reset_mid;
    cs_n = 1'b0;
    tick;
    rec_data = 8'h41;
    rec_done = 1'b1;
    tick;
    rec_data = 8'h77;
    tick;
    rec_done = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int j = 0; j < 2; j++) for (int i = 0; i < 16; i++) mm[j][i] = 8'h00;
    tests++;
    if (regs16 !== '0 || regs12 !== '0 || rs[0] !== 8'hA5 || rs[1] !== 8'hA5 ||
        ws !== 0 || ae !== 0 || cu !== 0 || bz !== 0) begin
      fails++;
      $display("FAIL reset_mid: regs16=%h regs12=%h resp=%h/%h ws=%b ae=%b cu=%b busy=%b, expected zeros and a5",
               regs16, regs12, rs[0], rs[1], ws, ae, cu, bz);
    end
    tick;
    cs_n = 1'b1;
    tick;
    tests++;
    if (cu !== 2'b00 || bz !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_close: cfg_update=%b busy=%b, expected 00 00", cu, bz);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_wrap;
    test_out_of_range;
    test_readback;
    test_back_to_back;
    test_simultaneous;
    test_abort;
    test_reset_mid;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_cfg_ctrl.md
# spi_cfg_ctrl

Command/register controller layered on the SPI slave byte driver. It interprets the received byte stream within one chip-select frame as a command byte plus data bytes, and writes or reads an internal bank of 8-bit configuration registers. It supplies the driver's `response_data` for the next byte and emits a commit strobe at frame end, so the downstream DDS logic applies a multi-byte update atomically.

## Interface
- `NREG`, 16: number of 8-bit config registers, 2..64.
- `ADDR_W`, 4: address width; must satisfy 2^ADDR_W >= NREG and ADDR_W <= 6.
- `STATUS_BYTE`, 8'hA5: byte returned while no read data is pending.
- `RESET_VAL`, 8'h00: reset value of every register.

- `clk`  in  1  system clock; same clock as the SPI slave driver.
- `rst`  in  1  synchronous, active-high reset.
- `rec_data`  in  8  byte from driver; valid when `rec_done`=1.
- `rec_done`  in  1  one-cycle pulse per completed byte.
- `cs_n`  in  1  chip select, same net fed to driver, active low.
- `response_data`  out  8  byte the driver shifts out next.
- `cfg_regs`  out  8*NREG  flattened register bank, reg i at [8i+7:8i].
- `wr_strobe`  out  1  one-cycle pulse per register write.
- `wr_addr`  out  ADDR_W  address of the write flagged by `wr_strobe`.
- `cfg_update`  out  1  one-cycle commit pulse at frame end if the frame wrote.
- `addr_err`  out  1  one-cycle pulse on any access to address >= NREG.
- `busy`  out  1  high while a frame is open (state != IDLE).

## Operation
- Command byte: bit7 RW (1=read), bit6 INC (1=auto-increment), bits[ADDR_W-1:0] start address. Other bits are ignored.
- States:
  - IDLE: `cs_n` high.
  - CMD: frame open, waiting for the command byte.
  - WR: data bytes are register writes.
  - RD: data bytes are dummies; registers are returned.
- Transitions:
  - IDLE→CMD when registered `cs_n`=0.
  - CMD→WR or CMD→RD on `rec_done`, selected by bit7.
  - Any state→IDLE when registered `cs_n`=1.
- Address pointer `ptr` loads from the command byte. After each data byte, `ptr` increments if INC=1, modulo NREG (NREG-1 wraps to 0). With INC=0, `ptr` holds.
- WR, on `rec_done`:
  - If `ptr` < NREG: `reg[ptr]`←`rec_data`, pulse `wr_strobe` with `wr_addr`=`ptr`.
  - Else: drop the write and pulse `addr_err`.
  - Set the `wrote` flag.
- RD: `response_data`=`reg[ptr]` (8'h00 with an `addr_err` pulse if out of range).
  - Loaded after the command byte, then reloaded after each dummy byte with the advanced `ptr`.
- IDLE, CMD and WR: `response_data`=STATUS_BYTE.
- `rec_done` while registered `cs_n`=1 is ignored.
- Frame end: on the `cs_n` rising edge (registered `cs_n_d`=0, `cs_n`=1), pulse `cfg_update` if `wrote`, then clear `wrote`.
- A frame that ends mid-byte discards the partial byte (the driver gives no `rec_done`) and returns to IDLE.

## Timing
- Reset values:
  - `response_data`=STATUS_BYTE.
  - All `cfg_regs`=RESET_VAL.
  - `wr_strobe`, `wr_addr`, `cfg_update`, `addr_err`, `busy`=0.
  - State IDLE, `ptr`=0, `wrote`=0.
- `rec_done` in cycle t:
  - Register write is visible on `cfg_regs` from t+1.
  - `wr_strobe` and `addr_err` are high during t+1.
  - New `response_data` is valid from t+1, well before the next SCLK edge.
- `cs_n` passes through one register stage. `busy` and state follow `cs_n` with 1-cycle latency.
- `cfg_update` is high in the cycle after the rising edge is detected.
- Simultaneous `rec_done` and `cs_n` rise: the write is applied first and counts toward `wrote`, so `cfg_update` still fires.
- `rst` mid-frame: all state and registers return to reset values next cycle; no `cfg_update`.
- Back-to-back frames (`cs_n` high for one clk): handled correctly; each frame needs its own command byte.

## Configuration
- `SPI_CFG_CTRL_READBACK_EN` defined: RD state and register readback implemented as above.
- Not defined:
  - Read commands move to a discard state; data bytes are ignored.
  - `response_data` is constantly STATUS_BYTE.
  - The read mux is removed.

## Structure
- Package `spi_cfg_pkg`:
  - State enum: IDLE/CMD/WR/RD.
  - Command bit positions: CMD_RW_BIT=7, CMD_INC_BIT=6.
  - Default STATUS_BYTE.
- Sub-module `cfg_reg_bank`:
  - NREG×8 storage with synchronous write port and combinational read mux.
  - Out-of-range read returns 0.
- Sequencing FSM, pointer, `cs_n` edge detection and strobes live in `spi_cfg_ctrl`.

## Test plan
- Write: frame {8'h43, 8'h11, 8'h22, 8'h33} → regs 3,4,5 = 11/22/33, three `wr_strobe` pulses with `wr_addr` 3,4,5, one `cfg_update` after `cs_n` rises.
- Wrap, NREG=16: {8'h4F, 8'hAA, 8'hBB} → reg15=AA, reg0=BB.
- Out-of-range, NREG=12: {8'h0E, 8'h55} → no write, `addr_err` pulse, `cfg_update` still fires (`wrote` set).
- Readback (EN defined): preload reg2=8'h5C, reg3=8'hC5; frame {8'hC2, dummy, dummy} → MISO bytes A5, 5C, C5; no `cfg_update`.
- Abort: `cs_n` rises after 4 SCLKs of the command byte → no write, no `cfg_update`, `busy` falls 1 cycle later.
- Reset: assert `rst` mid-write frame → `cfg_regs`=RESET_VAL, `response_data`=A5, all strobes low.
